// File: rtl/alu32_pkg.sv
// Shared definitions for the ALU32 result checker: op encodings,
// FSM state type and the default vector/counter width.
package alu32_pkg;

  localparam int VEC_W_DEF = 12;

  // One-hot ALU operation codes as driven on in_f.
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b010000;
  localparam logic [5:0] OP_AND = 6'b001000;
  localparam logic [5:0] OP_OR  = 6'b000100;
  localparam logic [5:0] OP_XOR = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b000001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/alu32_checker_if.sv
// Observed-ALU beat bus: one result beat per valid/ready handshake.
interface alu32_checker_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [5:0]  in_f;
  logic [31:0] in_out;
  logic        in_zero;
  logic        in_ov;

  // Side that presents ALU beats (the ALU under observation / a driver).
  modport master (
    output in_valid, in_a, in_b, in_f, in_out, in_zero, in_ov,
    input  in_ready
  );

  // Side that consumes ALU beats (the checker).
  modport slave (
    input  in_valid, in_a, in_b, in_f, in_out, in_zero, in_ov,
    output in_ready
  );

endinterface

// File: rtl/alu32_ref.sv
// Combinational golden ALU: expected result, zero and overflow for one
// beat, plus a flag telling whether the op code is a legal one-hot value.
module alu32_ref
  import alu32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [5:0]  f,
  output logic [31:0] out,
  output logic        zero,
  output logic        ov,
  output logic        is_onehot
);

  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  // Pick the expected result and signed overflow for the selected op.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    out = '0;
    ov  = 1'b0;
    case (f)
      OP_ADD: begin
        out = sum;
        ov  = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      OP_SUB: begin
        out = diff;
        ov  = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      OP_AND:  out = a & b;
      OP_OR:   out = a | b;
      OP_XOR:  out = a ^ b;
      OP_NOR:  out = ~(a | b);
      default: begin
        out = '0;
        ov  = 1'b0;
      end
    endcase
  end

  assign zero      = (out == '0);
  assign is_onehot = $onehot(f);

endmodule

// File: rtl/alu32_checker.sv
// ALU32 result checker. Accepts `total` observed ALU beats, compares each
// against a golden model through a two-stage pipeline, and reports pass /
// fail counts, the first failing index and a sticky illegal-op flag.
module alu32_checker
  import alu32_pkg::*;
#(
  parameter int VEC_W = VEC_W_DEF
) (
  input  logic             m_clock,
  input  logic             p_reset,
  input  logic             start,
  input  logic [VEC_W-1:0] total,
  alu32_checker_if.slave   obs,
  output logic             busy,
  output logic             done,
  output logic [VEC_W-1:0] pass_count,
  output logic [VEC_W-1:0] fail_count,
  output logic             first_fail_valid,
  output logic [VEC_W-1:0] first_fail_idx,
  output logic             bad_op
);

  state_t           state;
  logic             ready_q;
  logic [VEC_W-1:0] total_q;
  logic [VEC_W-1:0] acc_cnt;
  logic             drain_cnt;
  logic             accept;
  logic             last_beat;
  logic             start_ok;

  // Stage 1: captured beat and its run index.
  logic             s1_valid;
  logic [31:0]      s1_a;
  logic [31:0]      s1_b;
  logic [5:0]       s1_f;
  logic [31:0]      s1_out;
  logic             s1_zero;
  logic             s1_ov;
  logic [VEC_W-1:0] s1_idx;

  // Stage 2: registered verdict waiting to hit the counters.
  logic             s2_valid;
  logic             s2_pass;
  logic             s2_bad;
  logic [VEC_W-1:0] s2_idx;

  logic [31:0]      exp_out;
  logic             exp_zero;
  logic             exp_ov;
  logic             exp_onehot;
  logic             beat_ok;

  assign obs.in_ready = ready_q;
  assign accept       = obs.in_valid && ready_q;
  assign last_beat    = (acc_cnt == (total_q - VEC_W'(1)));
  assign start_ok     = start && ((state == IDLE) || (state == DONE));

  alu32_ref u_ref (
    .a         (s1_a),
    .b         (s1_b),
    .f         (s1_f),
    .out       (exp_out),
    .zero      (exp_zero),
    .ov        (exp_ov),
    .is_onehot (exp_onehot)
  );

  assign beat_ok = exp_onehot && (s1_out == exp_out) &&
                   (s1_zero == exp_zero) && (s1_ov == exp_ov);

  // Run-control FSM with registered ready/busy/done.
  always_ff @(posedge m_clock) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values, independent of statement order.
    if (p_reset) begin
      state     <= IDLE;
      ready_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      total_q   <= '0;
      acc_cnt   <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            total_q <= total;
            acc_cnt <= '0;
            if (total != '0) begin
              state   <= RUN;
              ready_q <= 1'b1;
              busy    <= 1'b1;
              done    <= 1'b0;
            end else begin
              state   <= DONE;
              ready_q <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            acc_cnt <= acc_cnt + VEC_W'(1);
            if (last_beat) begin
              state     <= DRAIN;
              ready_q   <= 1'b0;
              drain_cnt <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Two cycles: the final beat passes stage 1 then stage 2.
          if (drain_cnt) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pipeline valid bits; reset drops any beat still in flight.
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
    end
  end

  // Pipeline payload, loaded alongside its valid bit.
  always_ff @(posedge m_clock) begin
    // NOTE: payload flops are deliberately not reset; they are only ever
    // consumed when the matching valid bit (which is reset) is set.
    if (accept) begin
      s1_a    <= obs.in_a;
      s1_b    <= obs.in_b;
      s1_f    <= obs.in_f;
      s1_out  <= obs.in_out;
      s1_zero <= obs.in_zero;
      s1_ov   <= obs.in_ov;
      s1_idx  <= acc_cnt;
    end
    if (s1_valid) begin
      s2_pass <= beat_ok;
      s2_bad  <= !exp_onehot;
      s2_idx  <= s1_idx;
    end
  end

  // Result counters, first-failure capture and sticky bad-op flag.
  always_ff @(posedge m_clock) begin
    if (p_reset || start_ok) begin
      pass_count       <= '0;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      bad_op           <= 1'b0;
    end else if (s2_valid) begin
      if (s2_pass) begin
        if (pass_count != '1) pass_count <= pass_count + VEC_W'(1);
      end else begin
        if (fail_count != '1) fail_count <= fail_count + VEC_W'(1);
        if (!first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_idx   <= s2_idx;
        end
      end
      if (s2_bad) bad_op <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu32_checker.sv
// Self-checking bench for alu32_checker: directed scenarios plus random
// runs scored against a signed-arithmetic ALU model.
module tb_alu32_checker;

  localparam int VEC_W = 12;
  localparam int MAXV  = 64;
  localparam longint MAXS = 2147483647;
  localparam longint MINS = -MAXS - 1;

  logic             m_clock = 1'b0;
  logic             p_reset = 1'b1;
  logic             start   = 1'b0;
  logic [VEC_W-1:0] total   = '0;
  logic             busy, done, first_fail_valid, bad_op;
  logic [VEC_W-1:0] pass_count, fail_count, first_fail_idx;

  alu32_checker_if obs();

  alu32_checker #(.VEC_W(VEC_W)) dut (
    .m_clock          (m_clock),
    .p_reset          (p_reset),
    .start            (start),
    .total            (total),
    .obs              (obs),
    .busy             (busy),
    .done             (done),
    .pass_count       (pass_count),
    .fail_count       (fail_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_idx   (first_fail_idx),
    .bad_op           (bad_op)
  );

  always #5 m_clock = ~m_clock;

  int checks   = 0;
  int failures = 0;

  // Beat table for the next run: operands, op and the values the
  // "observed ALU" reports.
  logic [31:0] va[MAXV];
  logic [31:0] vb[MAXV];
  logic [5:0]  vf[MAXV];
  logic [31:0] vo[MAXV];
  logic        vz[MAXV];
  logic        vv[MAXV];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference ALU from signed integer arithmetic.
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                    input logic [5:0] f, output logic [31:0] o,
                                    output logic z, output logic v);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 0;
    o  = '0;
    v  = 1'b0;
    case (f)
      6'b100000: begin r = sa + sb; o = r[31:0]; v = (r > MAXS) || (r < MINS); end
      6'b010000: begin r = sa - sb; o = r[31:0]; v = (r > MAXS) || (r < MINS); end
      6'b001000: o = a & b;
      6'b000100: o = a | b;
      6'b000010: o = a ^ b;
      6'b000001: o = ~(a | b);
      default:   o = '0;
    endcase
    z = (o == 32'h0);
  endfunction

  task automatic set_beat(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] f, input logic [31:0] o,
                          input logic z, input logic v);
    va[i] = a; vb[i] = b; vf[i] = f; vo[i] = o; vz[i] = z; vv[i] = v;
  endtask

  task automatic set_good(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] f);
    logic [31:0] o;
    logic z, v;
    ref_model(a, b, f, o, z, v);
    set_beat(i, a, b, f, o, z, v);
  endtask

  task automatic drive_beat(input int i);
    obs.in_valid = 1'b1;
    obs.in_a = va[i]; obs.in_b = vb[i]; obs.in_f = vf[i];
    obs.in_out = vo[i]; obs.in_zero = vz[i]; obs.in_ov = vv[i];
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ready"}, obs.in_ready, 0);
    check({tag, "_pass"}, pass_count, 0);
    check({tag, "_fail"}, fail_count, 0);
    check({tag, "_ffv"}, first_fail_valid, 0);
    check({tag, "_ffi"}, first_fail_idx, 0);
    check({tag, "_badop"}, bad_op, 0);
  endtask

  // One complete run of n (>=1) beats from the table; optionally pokes
  // start while the run is in progress, which must be ignored.
  task automatic run(input string tag, input int n, input bit poke);
    int ep, ef, ffi, cnt;
    bit ffv, eb, ok;
    logic [31:0] o;
    logic z, v;
    ep = 0; ef = 0; ffi = 0; ffv = 0; eb = 0;
    for (int i = 0; i < n; i++) begin
      ref_model(va[i], vb[i], vf[i], o, z, v);
      ok = ($countones(vf[i]) == 1) && (o == vo[i]) && (z == vz[i]) && (v == vv[i]);
      if ($countones(vf[i]) != 1) eb = 1;
      if (ok) ep++;
      else begin
        ef++;
        if (!ffv) begin ffv = 1; ffi = i; end
      end
    end
    if (ep > 4095) ep = 4095;
    if (ef > 4095) ef = 4095;

    @(negedge m_clock);
    start = 1'b1;
    total = VEC_W'(n);
    @(negedge m_clock);
    start = 1'b0;
    check({tag, "_busy_start"}, busy, 1);

    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        obs.in_valid = 1'b0;
        obs.in_a = $urandom; obs.in_out = $urandom;
        if (poke && ($urandom_range(0, 1) == 1)) begin
          start = 1'b1;
          total = '0;
        end
        @(negedge m_clock);
        start = 1'b0;
      end
      drive_beat(i);
      check({tag, "_ready_run"}, obs.in_ready, 1);
      @(negedge m_clock);
      obs.in_valid = 1'b0;
    end

    // One cycle after the final accept edge; start here lands in DRAIN.
    if (poke) begin
      start = 1'b1;
      total = VEC_W'(3);
    end
    cnt = 1;
    while (!done && cnt < 10) begin
      @(negedge m_clock);
      start = 1'b0;
      cnt++;
    end
    start = 1'b0;
    check({tag, "_done_lat"}, cnt, 3);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_ready_end"}, obs.in_ready, 0);
    check({tag, "_pass"}, pass_count, ep);
    check({tag, "_fail"}, fail_count, ef);
    check({tag, "_ffv"}, first_fail_valid, ffv);
    check({tag, "_ffi"}, first_fail_idx, ffi);
    check({tag, "_badop"}, bad_op, eb);
  endtask

  task automatic gen_random(input int i);
    logic [31:0] corner[6];
    logic [31:0] a, b;
    logic [5:0]  f;
    corner = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h55555555};
    a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
    b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
    if ($urandom_range(0, 9) == 0) begin
      f = 6'($urandom);
      while ($countones(f) == 1) f = 6'($urandom);
    end else begin
      f = 6'(6'b1 << $urandom_range(0, 5));
    end
    set_good(i, a, b, f);
    if ($urandom_range(0, 9) < 3) begin
      case ($urandom_range(0, 2))
        0:       vo[i] = vo[i] ^ (32'h1 << $urandom_range(0, 31));
        1:       vz[i] = ~vz[i];
        default: vv[i] = ~vv[i];
      endcase
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    obs.in_valid = 1'b0;
    obs.in_a = '0; obs.in_b = '0; obs.in_f = '0;
    obs.in_out = '0; obs.in_zero = 1'b0; obs.in_ov = 1'b0;

    // Reset state.
    p_reset = 1'b1;
    repeat (3) @(negedge m_clock);
    check_all_zero("reset");
    p_reset = 1'b0;

    // in_valid in IDLE is ignored, then a zero-length run.
    for (int k = 0; k < 4; k++) begin
      set_good(0, $urandom, $urandom, 6'b100000);
      vo[0] = ~vo[0];
      drive_beat(0);
      @(negedge m_clock);
      check("idle_ready", obs.in_ready, 0);
    end
    obs.in_valid = 1'b0;
    repeat (3) @(negedge m_clock);
    check("idle_pass", pass_count, 0);
    check("idle_fail", fail_count, 0);
    start = 1'b1;
    total = '0;
    @(negedge m_clock);
    start = 1'b0;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_pass", pass_count, 0);
    check("zero_fail", fail_count, 0);

    // Three matching beats.
    set_beat(0, 32'h5, 32'h3, 6'b100000, 32'h8, 1'b0, 1'b0);
    set_beat(1, 32'h5, 32'h5, 6'b010000, 32'h0, 1'b1, 1'b0);
    set_beat(2, 32'hF0F0F0F0, 32'h0F0F0F0F, 6'b000100, 32'hFFFFFFFF, 1'b0, 1'b0);
    run("basic3", 3, 0);

    // Signed overflow on add: missing ov fails, correct ov passes.
    set_beat(0, 32'h7FFFFFFF, 32'h1, 6'b100000, 32'h80000000, 1'b0, 1'b0);
    run("ovmiss", 1, 0);
    set_beat(0, 32'h7FFFFFFF, 32'h1, 6'b100000, 32'h80000000, 1'b0, 1'b1);
    run("ovok", 1, 0);

    // Wrong nor result at index 2.
    set_good(0, 32'h12345678, 32'h9ABCDEF0, 6'b000010);
    set_good(1, 32'h80000000, 32'h80000000, 6'b010000);
    set_beat(2, 32'h0, 32'h0, 6'b000001, 32'h00000000, 1'b1, 1'b0);
    set_good(3, 32'hFFFF0000, 32'h00FFFF00, 6'b001000);
    run("nor_idx2", 4, 0);

    // Non-one-hot op.
    set_beat(0, 32'h1, 32'h2, 6'b000011, 32'h3, 1'b0, 1'b0);
    run("badop", 1, 0);

    // Reset in the middle of a run, colliding with start and in_valid.
    for (int i = 0; i < 3; i++) set_good(i, $urandom, $urandom, 6'b100000);
    @(negedge m_clock);
    start = 1'b1;
    total = VEC_W'(5);
    @(negedge m_clock);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_beat(i);
      @(negedge m_clock);
    end
    drive_beat(2);
    p_reset = 1'b1;
    start   = 1'b1;
    total   = VEC_W'(2);
    @(negedge m_clock);
    p_reset = 1'b0;
    start   = 1'b0;
    obs.in_valid = 1'b0;
    check_all_zero("midreset");
    repeat (3) @(negedge m_clock);
    check("midreset_noleak_pass", pass_count, 0);
    check("midreset_noleak_fail", fail_count, 0);
    check("midreset_idle_busy", busy, 0);
    set_good(0, 32'hDEADBEEF, 32'h01234567, 6'b010000);
    run("after_reset", 1, 0);

    // Random runs.
    for (int r = 0; r < 25; r++) begin
      int n;
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) gen_random(i);
      run($sformatf("rand%0d", r), n, bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
